// File: rtl/pixel_pkg.sv
// pixel_pkg: state encoding and Gray-to-binary helper shared by the pixel frame controller
// Contents: state_t (frame sequencer states), gray2bin (32-bit Gray decode, callers truncate)
package pixel_pkg;
    typedef enum logic [2:0] {IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_SETTLE, S_STREAM} state_t;
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) b = b ^ (g >> i);
        return b;
    endfunction
endpackage

// File: rtl/pixel_adc_ramp.sv
// pixel_adc_ramp: ADC ramp counter broadcast to the pixel latches during conversion
// Ports: i_clk/i_rst clock and async reset; i_clr forces the ramp to 0; i_en runs the ramp;
//        o_code ramp code (Gray or binary, 0 when disabled); o_last high on the final ramp step
module pixel_adc_ramp #(
    parameter int N_BITS = 8,
    parameter int GRAY   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_en,
    output logic [N_BITS-1:0] o_code,
    output logic              o_last
);
    logic [N_BITS-1:0] r_k;
    // The ramp sits at 0 whenever disabled, so every conversion starts from code 0 and never wraps
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_k <= '0;
        else r_k <= (i_clr || !i_en || o_last) ? '0 : r_k + 1'b1;
    end
    assign o_last = i_en && (r_k == '1);
    assign o_code = !i_en ? '0 : (GRAY != 0) ? (r_k ^ (r_k >> 1)) : r_k;
endmodule

// File: rtl/pixel_sensor_ctrl.sv
// pixel_sensor_ctrl: ERASE/EXPOSE/CONVERT/READ frame sequencer with a valid/ready pixel stream
// Ports: i_clk/i_rst clock and async reset; i_start, i_continuous, i_abort frame control;
//        i_expose_cyc exposure length; o_erase/o_expose/o_convert phase strobes; o_read row select;
//        o_adc_code ramp broadcast; i_pix_data selected-row codes; o_out_* pixel stream with i_out_ready;
//        o_frame_done end-of-frame pulse; o_busy not idle
module pixel_sensor_ctrl
    import pixel_pkg::*;
#(
    parameter int ROW        = 4,
    parameter int COL        = 4,
    parameter int N_BITS     = 8,
    parameter int ERASE_CYC  = 5,
    parameter int SETTLE_CYC = 2,
    parameter int EXP_W      = 16,
    parameter int GRAY       = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_continuous,
    input  logic                    i_abort,
    input  logic [EXP_W-1:0]        i_expose_cyc,
    output logic                    o_erase,
    output logic                    o_expose,
    output logic                    o_convert,
    output logic [ROW-1:0]          o_read,
    output logic [N_BITS-1:0]       o_adc_code,
    input  logic [COL*N_BITS-1:0]   i_pix_data,
    output logic [N_BITS-1:0]       o_out_data,
    output logic [$clog2(ROW)-1:0]  o_out_row,
    output logic [$clog2(COL)-1:0]  o_out_col,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic                    o_frame_done,
    output logic                    o_busy
);
    localparam int RW  = $clog2(ROW);
    localparam int CLW = $clog2(COL);
    state_t              r_state, w_next;
    logic [EXP_W-1:0]    r_cnt, r_exp;
    logic [RW-1:0]       r_row;
    logic [CLW-1:0]      r_col;
    logic [COL*N_BITS-1:0] r_rowbuf;
    logic                r_done, r_erase, r_expose, r_convert, r_busy;
    logic                w_last_code, w_xfer, w_last_col, w_last_row, w_hold_cnt;
    logic [N_BITS-1:0]   w_code, w_pix;
    pixel_adc_ramp #(.N_BITS(N_BITS), .GRAY(GRAY)) u_ramp (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (i_abort),
        .i_en   (r_state == S_CONVERT),
        .o_code (w_code),
        .o_last (w_last_code)
    );
    assign w_xfer     = o_out_valid && i_out_ready;
    assign w_last_col = r_col == CLW'(COL - 1);
    assign w_last_row = r_row == RW'(ROW - 1);
    // Phase counter only matters in timed states; parking it at 0 elsewhere keeps it from wrapping
    assign w_hold_cnt = (r_state == IDLE) || (r_state == S_CONVERT) || (r_state == S_STREAM);
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = i_start ? S_ERASE : IDLE;
            S_ERASE:   w_next = (r_cnt == EXP_W'(ERASE_CYC - 1)) ? S_EXPOSE : S_ERASE;
            S_EXPOSE:  w_next = (r_cnt == r_exp - 1'b1) ? S_CONVERT : S_EXPOSE;
            S_CONVERT: w_next = w_last_code ? S_SETTLE : S_CONVERT;
            // SETTLE_CYC cycles with the row selected, then one cycle with READ released
            S_SETTLE:  w_next = (r_cnt == EXP_W'(SETTLE_CYC)) ? S_STREAM : S_SETTLE;
            S_STREAM:  if (w_xfer && w_last_col) w_next = !w_last_row ? S_SETTLE : i_continuous ? S_ERASE : IDLE;
            default:   w_next = IDLE;
        endcase
        if (i_abort) w_next = IDLE;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_exp     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_rowbuf  <= '0;
            r_done    <= 1'b0;
            r_erase   <= 1'b0;
            r_expose  <= 1'b0;
            r_convert <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_erase   <= w_next == S_ERASE;
            r_expose  <= w_next == S_EXPOSE;
            r_convert <= w_next == S_CONVERT;
            r_busy    <= w_next != IDLE;
            r_cnt     <= (w_next != r_state || w_hold_cnt) ? '0 : r_cnt + 1'b1;
            r_done    <= !i_abort && w_xfer && w_last_col && w_last_row;
            // Zero exposure is promoted to one cycle so the EXPOSE compare stays meaningful
            if (r_state == IDLE && i_start && !i_abort) r_exp <= (i_expose_cyc == '0) ? EXP_W'(1) : i_expose_cyc;
            if (r_state == S_SETTLE && r_cnt == EXP_W'(SETTLE_CYC - 1)) r_rowbuf <= i_pix_data;
            if (i_abort || r_state == IDLE) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_xfer) begin
                r_col <= w_last_col ? '0 : r_col + 1'b1;
                if (w_last_col) r_row <= w_last_row ? '0 : r_row + 1'b1;
            end
        end
    end
    assign w_pix        = r_rowbuf[r_col*N_BITS +: N_BITS];
    assign o_erase      = r_erase;
    assign o_expose     = r_expose;
    assign o_convert    = r_convert;
    assign o_busy       = r_busy;
    assign o_frame_done = r_done;
    assign o_adc_code   = w_code;
    assign o_read       = (r_state == S_SETTLE && r_cnt < EXP_W'(SETTLE_CYC)) ? ROW'(1) << r_row : '0;
    assign o_out_valid  = r_state == S_STREAM;
    assign o_out_data   = !o_out_valid ? '0 : (GRAY != 0) ? N_BITS'(gray2bin(32'(w_pix))) : w_pix;
    assign o_out_row    = o_out_valid ? r_row : '0;
    assign o_out_col    = o_out_valid ? r_col : '0;
endmodule

// File: tb/tb_pixel_sensor_ctrl.sv
// tb_pixel_sensor_ctrl: directed frame sequences against a behavioural pixel array
module tb_pixel_sensor_ctrl;
    localparam int ROW = 4;
    localparam int COL = 4;
    localparam int NB  = 8;
    logic clk = 0, rst = 1, start = 0, cont = 0, abort = 0, ready = 1;
    logic [15:0] exp_cyc = 16'd10;
    logic erase, expose, convert, valid, done, busy;
    logic [ROW-1:0] rd;
    logic [NB-1:0] adc, od;
    logic [1:0] orow, ocol;
    logic [COL*NB-1:0] pix;
    int checks = 0, errors = 0, cyc = 0, kc = 0;
    logic [NB-1:0] mem [ROW*COL];
    logic lat [ROW*COL];
    logic [NB-1:0] codes [256];
    pixel_sensor_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_continuous(cont), .i_abort(abort),
        .i_expose_cyc(exp_cyc), .o_erase(erase), .o_expose(expose), .o_convert(convert),
        .o_read(rd), .o_adc_code(adc), .i_pix_data(pix), .o_out_data(od), .o_out_row(orow),
        .o_out_col(ocol), .o_out_valid(valid), .i_out_ready(ready), .o_frame_done(done), .o_busy(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Pixel p trips once the ramp step count reaches p*10 and freezes the code on the bus
    always @(posedge clk) begin
        kc <= convert ? kc + 1 : 0;
        for (int p = 0; p < ROW*COL; p++) begin
            if (erase) lat[p] <= 1'b0;
            else if (convert && !lat[p] && kc >= p*10) begin
                lat[p] <= 1'b1;
                mem[p] <= adc;
            end
        end
    end
    always_comb begin
        pix = '0;
        for (int r = 0; r < ROW; r++)
            if (rd[r]) for (int c = 0; c < COL; c++) pix[c*NB +: NB] = mem[r*COL+c];
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic run_phases(input bit poke, output int ne, output int nx, output int nc);
        ne = 0;
        while (erase && ne < 1000) begin ne++; tick; end
        nx = 0;
        while (expose && nx < 1000) begin
            if (poke && nx == 2) start = 1;
            nx++;
            tick;
            start = 0;
        end
        nc = 0;
        while (convert && nc < 300) begin
            if (nc < 256) codes[nc] = adc;
            nc++;
            tick;
        end
    endtask
    task automatic collect(input bit rnd, output int np, output int nd, output int dcyc);
        logic pv, pr;
        logic [NB-1:0] pd;
        logic [1:0] prw, pcl;
        int n;
        np = 0; nd = 0; dcyc = 0; pv = 0; pr = 1; pd = 0; prw = 0; pcl = 0; n = 0;
        while (n < 3000) begin
            if (done) begin nd++; dcyc = cyc; break; end
            if (pv && !pr) begin
                chk("hold_valid", 32'(valid), 1);
                chk("hold_data", 32'(od), 32'(pd));
                chk("hold_row", 32'(orow), 32'(prw));
                chk("hold_col", 32'(ocol), 32'(pcl));
            end
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (valid && ready) begin
                chk("pix_data", 32'(od), (np/COL)*40 + (np%COL)*10);
                chk("pix_row", 32'(orow), np/COL);
                chk("pix_col", 32'(ocol), np%COL);
                np++;
            end
            pv = valid; pr = ready; pd = od; prw = orow; pcl = ocol;
            n++;
            tick;
        end
        ready = 1;
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int ne, nx, nc, np, nd, dc, c0, n;
        tick; tick;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_erase", 32'(erase), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_adc", 32'(adc), 0);
        chk("rst_read", 32'(rd), 0);
        chk("rst_done", 32'(done), 0);
        rst = 0;
        tick;
        // Frame 1: free-flowing stream, cycle-exact latency
        exp_cyc = 10; start = 1; tick; start = 0; c0 = cyc; exp_cyc = 3;
        chk("f1_erase", 32'(erase), 1);
        chk("f1_busy", 32'(busy), 1);
        run_phases(0, ne, nx, nc);
        chk("f1_erase_len", ne, 5);
        chk("f1_expose_len", nx, 10);
        chk("f1_convert_len", nc, 256);
        chk("adc0", 32'(codes[0]), 0);
        chk("adc1", 32'(codes[1]), 1);
        chk("adc2", 32'(codes[2]), 3);
        chk("adc3", 32'(codes[3]), 2);
        chk("adc4", 32'(codes[4]), 6);
        chk("adc100", 32'(codes[100]), 86);
        chk("adc255", 32'(codes[255]), 128);
        chk("settle_read0", 32'(rd), 1);
        chk("settle_adc_off", 32'(adc), 0);
        tick;
        chk("settle_read1", 32'(rd), 1);
        tick;
        chk("gap_read", 32'(rd), 0);
        chk("gap_valid", 32'(valid), 0);
        collect(0, np, nd, dc);
        chk("f1_pixels", np, 16);
        chk("f1_done", nd, 1);
        chk("f1_latency", dc - c0, 299);
        chk("f1_done_idle", 32'(busy), 0);
        tick;
        chk("f1_done_pulse", 32'(done), 0);
        // Frame 2: random back-pressure, START poked during EXPOSE
        exp_cyc = 10; start = 1; tick; start = 0; exp_cyc = 0;
        run_phases(1, ne, nx, nc);
        chk("f2_erase_len", ne, 5);
        chk("f2_expose_len", nx, 10);
        chk("f2_convert_len", nc, 256);
        collect(1, np, nd, dc);
        chk("f2_pixels", np, 16);
        chk("f2_done", nd, 1);
        tick;
        chk("f2_done_pulse", 32'(done), 0);
        chk("f2_idle", 32'(busy), 0);
        // Continuous mode with zero exposure, two frames back-to-back
        cont = 1; exp_cyc = 0; start = 1; tick; start = 0; exp_cyc = 10;
        run_phases(0, ne, nx, nc);
        chk("c1_erase_len", ne, 5);
        chk("c1_expose_len", nx, 1);
        collect(0, np, nd, dc);
        chk("c1_pixels", np, 16);
        chk("c1_done", nd, 1);
        chk("c1_rearm", 32'(erase), 1);
        run_phases(0, ne, nx, nc);
        cont = 0;
        chk("c2_erase_len", ne, 5);
        chk("c2_expose_len", nx, 1);
        chk("c2_convert_len", nc, 256);
        collect(0, np, nd, dc);
        chk("c2_pixels", np, 16);
        chk("c2_done", nd, 1);
        chk("c2_stop", 32'(erase), 0);
        chk("c2_idle", 32'(busy), 0);
        // Abort at ramp step 100
        exp_cyc = 10; start = 1; tick; start = 0;
        n = 0;
        while ((erase || expose) && n < 100) begin n++; tick; end
        n = 0;
        while (convert && n < 100) begin n++; tick; end
        chk("ab_step", n, 100);
        chk("ab_adc", 32'(adc), 86);
        abort = 1;
        tick;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_convert", 32'(convert), 0);
        chk("ab_adc0", 32'(adc), 0);
        chk("ab_valid", 32'(valid), 0);
        chk("ab_done", 32'(done), 0);
        start = 1;
        tick;
        chk("ab_start_blocked", 32'(busy), 0);
        abort = 0; start = 0;
        tick;
        chk("ab_still_idle", 32'(busy), 0);
        start = 1; tick; start = 0;
        run_phases(0, ne, nx, nc);
        chk("ab_new_expose", nx, 10);
        collect(0, np, nd, dc);
        chk("ab_new_pixels", np, 16);
        chk("ab_new_done", nd, 1);
        // Asynchronous reset while a pixel is stalled on the stream
        start = 1; tick; start = 0;
        run_phases(0, ne, nx, nc);
        n = 0;
        while (!valid && n < 20) begin n++; tick; end
        chk("rs_valid", 32'(valid), 1);
        ready = 0;
        tick;
        #2 rst = 1;
        #1;
        chk("rs_valid0", 32'(valid), 0);
        chk("rs_busy0", 32'(busy), 0);
        chk("rs_data0", 32'(od), 0);
        tick;
        rst = 0; ready = 1;
        tick;
        chk("rs_idle", 32'(busy), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
